csr_unit: RTL and testbench

- CSR responder: services CSRWR (write) and CSRRD (read) requests issued by the execute/writeback path.
- Holds the scratch CSRs, the counter-control CSR and the free-running 48-bit cycle/instret counters.
- One request per handshake. Response registered one cycle later.
- Enforces kernel-only and read-only address windows, reporting violations through `ow_resp_err` so the pipeline can raise a trap.

---
 rtl/csr_unit.sv | 146 ++++++++++++++
 tb/tb_csr_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// CSR responder: scratch CSRs, counter control and 48-bit cycle/instret counters with tear-free HI shadows.
// Build option: define CSR_INSTRET_EN to implement the instret counter, its shadow and CNTCTL[1].
module csr_unit #(
  parameter int CSR_AW = 12,
  parameter int CSR_DW = 24,
  parameter int CNT_W  = 48
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req_valid,
  output logic              ow_req_ready,
  input  logic              iw_req_we,
  input  logic [CSR_AW-1:0] iw_req_addr,
  input  logic [CSR_DW-1:0] iw_req_wdata,
  input  logic              iw_mode_kernel,
  output logic              ow_resp_valid,
  input  logic              iw_resp_ready,
  output logic [CSR_DW-1:0] ow_resp_rdata,
  output logic              ow_resp_err,
  input  logic              iw_instr_retire
);
  localparam int HI_W = CNT_W - CSR_DW;
  localparam logic [CSR_AW-1:0] A_KSCR   = 'h800;
  localparam logic [CSR_AW-1:0] A_CNTCTL = 'h801;
  localparam logic [CSR_AW-1:0] A_CYC_LO = 'hC00;
  localparam logic [CSR_AW-1:0] A_CYC_HI = 'hC01;
`ifdef CSR_INSTRET_EN
  localparam logic [CSR_AW-1:0] A_IR_LO  = 'hC02;
  localparam logic [CSR_AW-1:0] A_IR_HI  = 'hC03;
  localparam logic              IR_EN    = 1'b1;
`else
  localparam logic              IR_EN    = 1'b0;
`endif

  logic [CSR_DW-1:0] r_scratch [4];
  logic [CSR_DW-1:0] r_kscratch;
  logic [1:0]        r_cntctl;
  logic [CNT_W-1:0]  r_cycle;
  logic [HI_W-1:0]   r_cycle_hi;
  logic              r_resp_valid;
  logic [CSR_DW-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_mapped;
  logic [CSR_DW-1:0] w_rdata;
  logic              w_priv_fault;
  logic              w_ro_fault;
  logic              w_err;
  logic              w_wr;
  logic              w_rd_ok;

  assign ow_req_ready  = !r_resp_valid || iw_resp_ready;
  assign ow_resp_valid = r_resp_valid;
  assign ow_resp_rdata = r_resp_rdata;
  assign ow_resp_err   = r_resp_err;
  assign w_accept      = iw_req_valid && ow_req_ready;

`ifdef CSR_INSTRET_EN
  logic [CNT_W-1:0] r_instret;
  logic [HI_W-1:0]  r_instret_hi;
`else
  logic w_unused_retire;
  assign w_unused_retire = iw_instr_retire;
`endif

  always_comb begin
    w_mapped = 1'b0;
    w_rdata  = '0;
    if (iw_req_addr[CSR_AW-1:2] == '0) begin
      w_mapped = 1'b1;
      w_rdata  = r_scratch[iw_req_addr[1:0]];
    end else begin
      case (iw_req_addr)
        A_KSCR:   begin w_mapped = 1'b1; w_rdata = r_kscratch; end
        A_CNTCTL: begin w_mapped = 1'b1; w_rdata = {{(CSR_DW-2){1'b0}}, r_cntctl}; end
        A_CYC_LO: begin w_mapped = 1'b1; w_rdata = r_cycle[CSR_DW-1:0]; end
        A_CYC_HI: begin w_mapped = 1'b1; w_rdata = CSR_DW'(r_cycle_hi); end
`ifdef CSR_INSTRET_EN
        A_IR_LO:  begin w_mapped = 1'b1; w_rdata = r_instret[CSR_DW-1:0]; end
        A_IR_HI:  begin w_mapped = 1'b1; w_rdata = CSR_DW'(r_instret_hi); end
`endif
        default: ;
      endcase
    end
  end

  // 0x800-0xBFF is the kernel window; 0xC00-0xCFF is the read-only counter window.
  assign w_priv_fault = (iw_req_addr[CSR_AW-1 -: 2] == 2'b10) && !iw_mode_kernel;
  assign w_ro_fault   = iw_req_we && (iw_req_addr[CSR_AW-1 -: 4] == 4'hC);
  assign w_err        = !w_mapped || w_priv_fault || w_ro_fault;
  assign w_wr         = w_accept && iw_req_we && !w_err;
  assign w_rd_ok      = w_accept && !iw_req_we && !w_err;

  // valid/ready: a request is taken when valid && ready; the response is held until
  // resp_ready is seen at an edge, and a new accept in that edge overwrites it directly.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= (w_err || iw_req_we) ? '0 : w_rdata;
      r_resp_err   <= w_err;
    end else if (iw_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      for (int i = 0; i < 4; i++) r_scratch[i] <= '0;
      r_kscratch <= '0;
      r_cntctl   <= {IR_EN, 1'b1};
    end else if (w_wr) begin
      if (iw_req_addr[CSR_AW-1:2] == '0) r_scratch[iw_req_addr[1:0]] <= iw_req_wdata;
      if (iw_req_addr == A_KSCR)         r_kscratch <= iw_req_wdata;
      if (iw_req_addr == A_CNTCTL)       r_cntctl <= {iw_req_wdata[1] & IR_EN, iw_req_wdata[0]};
    end
  end

  // Shadow captures the pre-increment HI, matching the LO value returned in the same edge.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_cycle    <= '0;
      r_cycle_hi <= '0;
    end else begin
      if (r_cntctl[0]) r_cycle <= r_cycle + CNT_W'(1);
      if (w_rd_ok && iw_req_addr == A_CYC_LO) r_cycle_hi <= r_cycle[CNT_W-1:CSR_DW];
    end
  end

`ifdef CSR_INSTRET_EN
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_instret    <= '0;
      r_instret_hi <= '0;
    end else begin
      if (r_cntctl[1] && iw_instr_retire) r_instret <= r_instret + CNT_W'(1);
      if (w_rd_ok && iw_req_addr == A_IR_LO) r_instret_hi <= r_instret[CNT_W-1:CSR_DW];
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: scenario tasks compared against a behavioural CSR model.
module tb_csr_unit;
  logic        iw_clk;
  logic        iw_rst;
  logic        iw_req_valid;
  logic        ow_req_ready;
  logic        iw_req_we;
  logic [11:0] iw_req_addr;
  logic [23:0] iw_req_wdata;
  logic        iw_mode_kernel;
  logic        ow_resp_valid;
  logic        iw_resp_ready;
  logic [23:0] ow_resp_rdata;
  logic        ow_resp_err;
  logic        iw_instr_retire;

  csr_unit dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_req_valid(iw_req_valid), .ow_req_ready(ow_req_ready),
    .iw_req_we(iw_req_we), .iw_req_addr(iw_req_addr), .iw_req_wdata(iw_req_wdata),
    .iw_mode_kernel(iw_mode_kernel),
    .ow_resp_valid(ow_resp_valid), .iw_resp_ready(iw_resp_ready),
    .ow_resp_rdata(ow_resp_rdata), .ow_resp_err(ow_resp_err),
    .iw_instr_retire(iw_instr_retire)
  );

  // ---------------- clock / reset ----------------
  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  int edge_n = 0;
  always @(posedge iw_clk) edge_n <= edge_n + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

`ifdef CSR_INSTRET_EN
  localparam logic [1:0] CTL_MASK = 2'b11;
`else
  localparam logic [1:0] CTL_MASK = 2'b01;
`endif

  // ---------------- reference model ----------------
  logic [23:0] m_scr [4];
  logic [23:0] m_kscr;
  logic [1:0]  m_ctl;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_scr[i] = '0;
    m_kscr = '0;
    m_ctl  = 2'b11 & CTL_MASK;
  endfunction

  // Non-counter CSR behaviour; counter reads are handled by the counter scenarios.
  function automatic void model_access(input logic we, input logic [11:0] a, input logic [23:0] wd,
                                       input logic kern, output logic [23:0] rd, output logic er);
    logic        mapped;
    logic [23:0] val;
    mapped = 1'b0;
    val    = '0;
    if (a <= 12'h003) begin mapped = 1'b1; val = m_scr[a[1:0]]; end
    else if (a == 12'h800) begin mapped = 1'b1; val = m_kscr; end
    else if (a == 12'h801) begin mapped = 1'b1; val = {22'b0, m_ctl}; end
    else if (a == 12'hC00 || a == 12'hC01) mapped = 1'b1;
    else if ((a == 12'hC02 || a == 12'hC03) && CTL_MASK[1]) mapped = 1'b1;
    er = !mapped || (a >= 12'h800 && a <= 12'hBFF && !kern) || (we && a >= 12'hC00 && a <= 12'hCFF);
    rd = (er || we) ? 24'h0 : val;
    if (we && !er) begin
      if (a <= 12'h003) m_scr[a[1:0]] = wd;
      else if (a == 12'h800) m_kscr = wd;
      else if (a == 12'h801) m_ctl = wd[1:0] & CTL_MASK;
    end
  endfunction

  // ---------------- driver ----------------
  logic        vld;
  logic        er;
  logic [23:0] rd;
  int          e;
  logic [23:0] xrd;
  logic        xer;

  task automatic do_req(input logic we_i, input logic [11:0] a, input logic [23:0] wd, input logic kern,
                        output logic o_vld, output logic [23:0] o_rd, output logic o_er, output int o_e);
    @(negedge iw_clk);
    iw_req_valid = 1'b1; iw_req_we = we_i; iw_req_addr = a; iw_req_wdata = wd; iw_mode_kernel = kern;
    @(posedge iw_clk); #1;
    o_vld = ow_resp_valid; o_rd = ow_resp_rdata; o_er = ow_resp_err; o_e = edge_n;
    iw_req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge iw_clk);
    iw_req_valid = 1'b0;
    @(posedge iw_clk); #1;
  endtask

  // ---------------- scenarios ----------------
  int rel_e;

  task automatic test_reset();
    iw_rst = 1'b0;
    repeat (2) @(posedge iw_clk);
    #1;
    checks++; if (ow_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ow_resp_valid); end
    checks++; if (ow_resp_rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 000000", ow_resp_rdata); end
    checks++; if (ow_resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", ow_resp_err); end
    checks++; if (ow_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ow_req_ready); end
    @(negedge iw_clk);
    iw_rst = 1'b1;
    rel_e = edge_n;
    model_reset();
  endtask

  task automatic test_cycle_from_reset();
    logic [47:0] cyc;
    do_req(1'b0, 12'hC00, 24'h0, 1'b0, vld, rd, er, e);
    cyc = 48'(e - rel_e - 1);
    checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== cyc[23:0]) begin errors++; $display("FAIL cycle_after_reset: got v=%b e=%b d=%h exp d=%h", vld, er, rd, cyc[23:0]); end
    do_req(1'b0, 12'hC01, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL cycle_hi_after_reset: got e=%b d=%h exp 000000", er, rd); end
    do_req(1'b0, 12'h801, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== {22'b0, CTL_MASK}) begin errors++; $display("FAIL cntctl_reset: got e=%b d=%h exp %h", er, rd, CTL_MASK); end
    do_req(1'b0, 12'h800, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL kscratch_reset: got e=%b d=%h exp 000000", er, rd); end
  endtask

  task automatic test_rw();
    model_access(1'b1, 12'h002, 24'h00EF12, 1'b0, xrd, xer);
    do_req(1'b1, 12'h002, 24'h00EF12, 1'b0, vld, rd, er, e);
    checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL rw_write: got v=%b e=%b d=%h exp v=1 e=0 d=0", vld, er, rd); end
    idle_cycle();
    checks++; if (ow_resp_valid !== 1'b0) begin errors++; $display("FAIL rw_retire: got valid=%b exp 0", ow_resp_valid); end
    model_access(1'b0, 12'h002, 24'h0, 1'b0, xrd, xer);
    do_req(1'b0, 12'h002, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 24'h00EF12) begin errors++; $display("FAIL rw_read: got v=%b e=%b d=%h exp d=00ef12", vld, er, rd); end
  endtask

  task automatic test_priv();
    model_access(1'b1, 12'h800, 24'h123456, 1'b0, xrd, xer);
    do_req(1'b1, 12'h800, 24'h123456, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b1 || rd !== 24'h0) begin errors++; $display("FAIL priv_user_write: got e=%b d=%h exp e=1 d=0", er, rd); end
    model_access(1'b0, 12'h800, 24'h0, 1'b1, xrd, xer);
    do_req(1'b0, 12'h800, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL priv_kernel_read0: got e=%b d=%h exp e=0 d=0", er, rd); end
    model_access(1'b1, 12'h800, 24'h000001, 1'b1, xrd, xer);
    do_req(1'b1, 12'h800, 24'h000001, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL priv_kernel_write: got e=%b exp 0", er); end
    model_access(1'b0, 12'h800, 24'h0, 1'b1, xrd, xer);
    do_req(1'b0, 12'h800, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'h000001) begin errors++; $display("FAIL priv_kernel_read1: got e=%b d=%h exp d=000001", er, rd); end
    do_req(1'b0, 12'h801, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b1 || rd !== 24'h0) begin errors++; $display("FAIL priv_user_cntctl: got e=%b d=%h exp e=1 d=0", er, rd); end
  endtask

  task automatic test_faults();
    do_req(1'b1, 12'hC00, 24'h000005, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b1 || rd !== 24'h0) begin errors++; $display("FAIL ro_write: got e=%b d=%h exp e=1 d=0", er, rd); end
    do_req(1'b0, 12'h321, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b1 || rd !== 24'h0) begin errors++; $display("FAIL unmapped_read: got e=%b d=%h exp e=1 d=0", er, rd); end
    do_req(1'b1, 12'h004, 24'hABCDEF, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_write: got e=%b exp 1", er); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [14];
    addrs = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h800, 12'h801, 12'h802,
              12'hBFF, 12'hC00, 12'hC01, 12'hC02, 12'hC05, 12'h321};
    for (int i = 0; i < 60; i++) begin
      logic [11:0] a;
      logic        we_r;
      logic        kern;
      logic [23:0] wd;
      a    = addrs[$urandom_range(0, 13)];
      we_r = 1'($urandom_range(0, 1));
      kern = 1'($urandom_range(0, 1));
      wd   = 24'($urandom());
      if (a[11:8] == 4'hC) we_r = 1'b1;
      model_access(we_r, a, wd, kern, xrd, xer);
      do_req(we_r, a, wd, kern, vld, rd, er, e);
      checks++;
      if (vld !== 1'b1 || rd !== xrd || er !== xer) begin
        errors++;
        $display("FAIL random[%0d] a=%h we=%b k=%b: got v=%b e=%b d=%h exp e=%b d=%h", i, a, we_r, kern, vld, er, rd, xer, xrd);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [23:0] wd;
      wd = 24'($urandom());
      model_access(1'b1, 12'(i), wd, 1'b0, xrd, xer);
      do_req(1'b1, 12'(i), wd, 1'b0, vld, rd, er, e);
    end
    for (int i = 3; i >= 0; i--) begin
      model_access(1'b0, 12'(i), 24'h0, 1'b0, xrd, xer);
      do_req(1'b0, 12'(i), 24'h0, 1'b0, vld, rd, er, e);
      checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== xrd) begin errors++; $display("FAIL b2b_read[%0d]: got v=%b e=%b d=%h exp d=%h", i, vld, er, rd, xrd); end
    end
  endtask

  task automatic test_counter_coherence();
    logic [47:0] f;
    logic [47:0] exp_c;
    int          rel;
    f = 48'h0000_00FF_FFFE;
    model_access(1'b1, 12'h801, 24'h000003, 1'b1, xrd, xer);
    do_req(1'b1, 12'h801, 24'h000003, 1'b1, vld, rd, er, e);
    @(negedge iw_clk);
    force dut.r_cycle = f;
    #1;
    release dut.r_cycle;
    rel = edge_n;
    do_req(1'b0, 12'hC00, 24'h0, 1'b0, vld, rd, er, e);
    exp_c = f + 48'(e - rel - 1);
    checks++; if (er !== 1'b0 || rd !== exp_c[23:0]) begin errors++; $display("FAIL coh_lo1: got e=%b d=%h exp d=%h", er, rd, exp_c[23:0]); end
    do_req(1'b0, 12'hC01, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== exp_c[47:24]) begin errors++; $display("FAIL coh_hi1: got e=%b d=%h exp d=%h", er, rd, exp_c[47:24]); end
    do_req(1'b0, 12'hC00, 24'h0, 1'b0, vld, rd, er, e);
    exp_c = f + 48'(e - rel - 1);
    checks++; if (er !== 1'b0 || rd !== exp_c[23:0]) begin errors++; $display("FAIL coh_lo2: got e=%b d=%h exp d=%h", er, rd, exp_c[23:0]); end
    do_req(1'b0, 12'hC01, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== exp_c[47:24]) begin errors++; $display("FAIL coh_hi2: got e=%b d=%h exp d=%h", er, rd, exp_c[47:24]); end
    // Freeze: the write edge still counts with the old enable.
    model_access(1'b1, 12'h801, 24'h000000, 1'b1, xrd, xer);
    do_req(1'b1, 12'h801, 24'h000000, 1'b1, vld, rd, er, e);
    exp_c = f + 48'(e - rel);
    do_req(1'b1, 12'hC00, 24'h000005, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL coh_ro_write: got e=%b exp 1", er); end
    repeat (10) idle_cycle();
    do_req(1'b0, 12'hC00, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== exp_c[23:0]) begin errors++; $display("FAIL coh_frozen_lo: got e=%b d=%h exp d=%h", er, rd, exp_c[23:0]); end
    do_req(1'b0, 12'hC01, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== exp_c[47:24]) begin errors++; $display("FAIL coh_frozen_hi: got e=%b d=%h exp d=%h", er, rd, exp_c[47:24]); end
  endtask

  task automatic test_backpressure();
    logic [23:0] v1;
    logic [23:0] v2;
    v1 = 24'($urandom());
    v2 = ~v1;
    model_access(1'b1, 12'h001, v1, 1'b0, xrd, xer);
    do_req(1'b1, 12'h001, v1, 1'b0, vld, rd, er, e);
    model_access(1'b1, 12'h002, v2, 1'b0, xrd, xer);
    do_req(1'b1, 12'h002, v2, 1'b0, vld, rd, er, e);
    idle_cycle();
    @(negedge iw_clk);
    iw_resp_ready = 1'b0;
    iw_req_valid = 1'b1; iw_req_we = 1'b0; iw_req_addr = 12'h001; iw_mode_kernel = 1'b0;
    @(posedge iw_clk); #1;
    checks++; if (ow_resp_valid !== 1'b1 || ow_resp_rdata !== v1) begin errors++; $display("FAIL bp_accept: got v=%b d=%h exp d=%h", ow_resp_valid, ow_resp_rdata, v1); end
    iw_req_addr = 12'h002;
    for (int c = 0; c < 3; c++) begin
      @(posedge iw_clk);
      @(negedge iw_clk);
      checks++; if (ow_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0", c, ow_req_ready); end
      checks++; if (ow_resp_valid !== 1'b1 || ow_resp_rdata !== v1 || ow_resp_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b e=%b d=%h exp d=%h", c, ow_resp_valid, ow_resp_err, ow_resp_rdata, v1); end
    end
    iw_resp_ready = 1'b1;
    #1;
    checks++; if (ow_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", ow_req_ready); end
    @(posedge iw_clk); #1;
    checks++; if (ow_resp_valid !== 1'b1 || ow_resp_rdata !== v2) begin errors++; $display("FAIL bp_pending: got v=%b d=%h exp d=%h", ow_resp_valid, ow_resp_rdata, v2); end
    iw_req_addr = 12'h001;
    @(posedge iw_clk); #1;
    checks++; if (ow_resp_valid !== 1'b1 || ow_resp_rdata !== v1) begin errors++; $display("FAIL bp_nobubble: got v=%b d=%h exp d=%h", ow_resp_valid, ow_resp_rdata, v1); end
    iw_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    model_access(1'b1, 12'h003, 24'hA5A5A5, 1'b0, xrd, xer);
    do_req(1'b1, 12'h003, 24'hA5A5A5, 1'b0, vld, rd, er, e);
    idle_cycle();
    @(negedge iw_clk);
    iw_resp_ready = 1'b0;
    iw_req_valid = 1'b1; iw_req_we = 1'b0; iw_req_addr = 12'h003; iw_mode_kernel = 1'b0;
    @(posedge iw_clk); #1;
    iw_req_valid = 1'b0;
    checks++; if (ow_resp_rdata !== 24'hA5A5A5 || ow_req_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_pre: got d=%h rdy=%b exp d=a5a5a5 rdy=0", ow_resp_rdata, ow_req_ready); end
    @(negedge iw_clk);
    iw_rst = 1'b0;
    #1;
    checks++; if (ow_resp_valid !== 1'b0 || ow_resp_rdata !== 24'h0 || ow_resp_err !== 1'b0 || ow_req_ready !== 1'b1) begin errors++; $display("FAIL rst_stall: got v=%b d=%h e=%b rdy=%b exp 0 000000 0 1", ow_resp_valid, ow_resp_rdata, ow_resp_err, ow_req_ready); end
    @(negedge iw_clk);
    iw_rst = 1'b1;
    iw_resp_ready = 1'b1;
    model_reset();
    model_access(1'b0, 12'h003, 24'h0, 1'b0, xrd, xer);
    do_req(1'b0, 12'h003, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== xrd) begin errors++; $display("FAIL rst_stall_scratch: got e=%b d=%h exp d=%h", er, rd, xrd); end
  endtask

  task automatic test_instret();
`ifdef CSR_INSTRET_EN
    model_access(1'b1, 12'h801, 24'h000003, 1'b1, xrd, xer);
    do_req(1'b1, 12'h801, 24'h000003, 1'b1, vld, rd, er, e);
    repeat (5) begin
      @(negedge iw_clk); iw_instr_retire = 1'b1;
      @(negedge iw_clk); iw_instr_retire = 1'b0;
    end
    do_req(1'b0, 12'hC02, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'd5) begin errors++; $display("FAIL instret_lo: got e=%b d=%h exp d=000005", er, rd); end
    do_req(1'b0, 12'hC03, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL instret_hi: got e=%b d=%h exp d=000000", er, rd); end
    model_access(1'b1, 12'h801, 24'h000001, 1'b1, xrd, xer);
    do_req(1'b1, 12'h801, 24'h000001, 1'b1, vld, rd, er, e);
    repeat (3) begin
      @(negedge iw_clk); iw_instr_retire = 1'b1;
      @(negedge iw_clk); iw_instr_retire = 1'b0;
    end
    do_req(1'b0, 12'hC02, 24'h0, 1'b0, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== 24'd5) begin errors++; $display("FAIL instret_disabled: got e=%b d=%h exp d=000005", er, rd); end
`else
    do_req(1'b0, 12'hC02, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b1 || rd !== 24'h0) begin errors++; $display("FAIL instret_absent_lo: got e=%b d=%h exp e=1 d=0", er, rd); end
    do_req(1'b0, 12'hC03, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL instret_absent_hi: got e=%b exp 1", er); end
    model_access(1'b1, 12'h801, 24'h000003, 1'b1, xrd, xer);
    do_req(1'b1, 12'h801, 24'h000003, 1'b1, vld, rd, er, e);
    model_access(1'b0, 12'h801, 24'h0, 1'b1, xrd, xer);
    do_req(1'b0, 12'h801, 24'h0, 1'b1, vld, rd, er, e);
    checks++; if (er !== 1'b0 || rd !== xrd) begin errors++; $display("FAIL cntctl_bit1_absent: got e=%b d=%h exp d=%h", er, rd, xrd); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    iw_rst = 1'b0;
    iw_req_valid = 1'b0;
    iw_req_we = 1'b0;
    iw_req_addr = '0;
    iw_req_wdata = '0;
    iw_mode_kernel = 1'b0;
    iw_resp_ready = 1'b1;
    iw_instr_retire = 1'b0;
    test_reset();
    test_cycle_from_reset();
    test_rw();
    test_priv();
    test_faults();
    test_random();
    test_back_to_back();
    test_counter_coherence();
    test_backpressure();
    test_reset_mid_stall();
    test_instret();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
